// File: rtl/sys_bridge_mc_if.sv
// rtl/sys_bridge_mc_if.sv - CPU data port and slave bus bundle for the multi-slave bridge.
// The slave modport is the bridge's view; the master modport drives the CPU and slave sides.
interface sys_bridge_mc_if #(
  parameter int NUM_SLV = 4
);
  logic                    pr_req;
  logic [31:0]             pr_addr;
  logic [31:0]             pr_wdata;
  logic [3:0]              pr_byteen;
  logic                    pr_busy;
  logic                    pr_done;
  logic                    pr_err;
  logic [31:0]             pr_rdata;
  logic [NUM_SLV-1:0]      slv_sel;
  logic                    slv_we;
  logic [31:0]             slv_addr;
  logic [31:0]             slv_wdata;
  logic [3:0]              slv_byteen;
  logic [NUM_SLV-1:0]      slv_ready;
  logic [NUM_SLV*32-1:0]   slv_rdata;

  modport slave (
    input  pr_req, pr_addr, pr_wdata, pr_byteen, slv_ready, slv_rdata,
    output pr_busy, pr_done, pr_err, pr_rdata,
    output slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen
  );

  modport master (
    output pr_req, pr_addr, pr_wdata, pr_byteen, slv_ready, slv_rdata,
    input  pr_busy, pr_done, pr_err, pr_rdata,
    input  slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen
  );
endinterface

// File: rtl/sys_bridge_mc.sv
// rtl/sys_bridge_mc.sv - Multi-slave bridge with range decode, ready handshake and timeout errors.
// One request in flight; every output comes straight from a flop.
module sys_bridge_mc #(
  parameter int                    NUM_SLV   = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE  = {32'h7F20, 32'h7F10, 32'h7F00, 32'h0},
  parameter logic [NUM_SLV*32-1:0] SLV_LIMIT = {32'h7F23, 32'h7F1B, 32'h7F0B, 32'h2FFF},
  parameter logic [NUM_SLV-1:0]    WORD_ONLY = 4'b1110,
  parameter int                    TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  sys_bridge_mc_if.slave       bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         byteen_q, byteen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               hit_any;
  logic               word_only;
  logic [NUM_SLV-1:0] slot_oh;
  logic               illegal;
  logic               ready_hit;
  logic [31:0]        sel_rdata;

  // Scan from the top slot down so the lowest matching index overrides.
  always_comb begin
    hit_any   = 1'b0;
    word_only = 1'b0;
    slot_oh   = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (bus.pr_addr >= SLV_BASE[i*32 +: 32] && bus.pr_addr <= SLV_LIMIT[i*32 +: 32]) begin
        hit_any    = 1'b1;
        slot_oh    = '0;
        slot_oh[i] = 1'b1;
        word_only  = WORD_ONLY[i];
      end
    end
    illegal = word_only && (bus.pr_byteen != 4'b0000) && (bus.pr_byteen != 4'b1111);
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | bus.slv_rdata[i*32 +: 32];
    end
    ready_hit = |(bus.slv_ready & sel_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.pr_req) begin
          addr_d   = bus.pr_addr;
          wdata_d  = bus.pr_wdata;
          byteen_d = bus.pr_byteen;
          cnt_d    = '0;
          if (!hit_any || illegal) begin
            state_d = S_ERR;
            sel_d   = '0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            sel_d   = slot_oh;
          end
        end
      end
      S_ACCESS: begin
        if (ready_hit) begin
          state_d = S_DONE;
          sel_d   = '0;
          rdata_d = sel_rdata;
          done_d  = 1'b1;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_ERR;
          sel_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        // Returning to IDLE clears the slave-side bus so IDLE always shows zeros.
        state_d  = S_IDLE;
        sel_d    = '0;
        addr_d   = '0;
        wdata_d  = '0;
        byteen_d = '0;
        cnt_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    we_d   = (|sel_d) && (byteen_d != 4'b0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.pr_busy    = busy_q;
  assign bus.pr_done    = done_q;
  assign bus.pr_err     = err_q;
  assign bus.pr_rdata   = rdata_q;
  assign bus.slv_sel    = sel_q;
  assign bus.slv_we     = we_q;
  assign bus.slv_addr   = addr_q;
  assign bus.slv_wdata  = wdata_q;
  assign bus.slv_byteen = byteen_q;

endmodule

// File: tb/tb_sys_bridge_mc.sv
// tb/tb_sys_bridge_mc.sv - Vector table plus scoreboard bench for sys_bridge_mc.
module tb_sys_bridge_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sys_bridge_mc_if #(.NUM_SLV(4)) bus ();

  sys_bridge_mc #(.NUM_SLV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_n;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        err;
    int          cycles;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cycles;
    int          selcnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},   32'(bus.pr_busy),    32'h0);
    check({tag, " done"},   32'(bus.pr_done),    32'h0);
    check({tag, " err"},    32'(bus.pr_err),     32'h0);
    check({tag, " rdata"},  bus.pr_rdata,        32'h0);
    check({tag, " sel"},    32'(bus.slv_sel),    32'h0);
    check({tag, " we"},     32'(bus.slv_we),     32'h0);
    check({tag, " addr"},   bus.slv_addr,        32'h0);
    check({tag, " wdata"},  bus.slv_wdata,       32'h0);
    check({tag, " byteen"}, 32'(bus.slv_byteen), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    int   selcnt;
    int   busycnt;
    bit   done;
    e.err    = v.err;
    e.rdata  = v.err ? 32'h0 : v.rdata;
    e.cycles = v.cycles;
    e.selcnt = (v.sel == 4'b0) ? 0 : (v.err ? 15 : v.wait_n + 1);
    sb_q.push_back(e);

    bus.pr_req    = 1'b1;
    bus.pr_addr   = v.addr;
    bus.pr_wdata  = v.wdata;
    bus.pr_byteen = v.be;
    for (int i = 0; i < 4; i++)
      bus.slv_rdata[i*32 +: 32] = v.sel[i] ? v.rdata : (32'hBAD0_0000 | 32'(i));

    cyc = 0; selcnt = 0; busycnt = 0; done = 0;
    got.err = 1'b0; got.rdata = '0; got.cycles = 0; got.selcnt = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      bus.slv_ready = '0;
      if (bus.pr_busy) busycnt++;
      if (bus.slv_sel != 4'b0) begin
        selcnt++;
        check({tag, " sel"}, 32'(bus.slv_sel), 32'(v.sel));
        if (selcnt == 1) begin
          check({tag, " slv_addr"},   bus.slv_addr,        v.addr);
          check({tag, " slv_wdata"},  bus.slv_wdata,       v.wdata);
          check({tag, " slv_byteen"}, 32'(bus.slv_byteen), 32'(v.be));
          check({tag, " slv_we"},     32'(bus.slv_we),     32'(v.be != 4'b0));
        end
        // Other slots raise ready while waiting; the bridge must ignore them.
        bus.slv_ready = (selcnt == v.wait_n + 1) ? v.sel : ~v.sel;
      end
      if (bus.pr_done) begin
        done       = 1;
        got.err    = bus.pr_err;
        got.rdata  = bus.pr_rdata;
        got.cycles = cyc;
        got.selcnt = selcnt;
      end
    end

    e = sb_q.pop_front();
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s no_done: got none after %0d cycles expected pr_done at %0d", tag, cyc, e.cycles);
    end else begin
      check({tag, " pr_err"},   32'(got.err),    32'(e.err));
      check({tag, " pr_rdata"}, got.rdata,       e.rdata);
      check({tag, " latency"},  32'(got.cycles), 32'(e.cycles));
      check({tag, " sel_cyc"},  32'(got.selcnt), 32'(e.selcnt));
      check({tag, " busy_cyc"}, 32'(busycnt),    32'(e.cycles));
    end

    bus.pr_req    = 1'b0;
    bus.slv_ready = '0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero({tag, " idle"});
  endtask

  vec_t vecs[15];

  initial begin
    vec_t rv;
    int   n;
    vecs[0]  = '{32'h0000_1004, 32'h1234_5678, 4'b0011, 0,  32'h1111_2222, 4'b0001, 1'b0, 2};
    vecs[1]  = '{32'h0000_7F14, 32'h0,         4'b0000, 3,  32'hDEAD_BEEF, 4'b0100, 1'b0, 5};
    vecs[2]  = '{32'h0000_5000, 32'h0,         4'b0000, 0,  32'h0,         4'b0000, 1'b1, 1};
    vecs[3]  = '{32'h0000_7F00, 32'h0000_00AA, 4'b0001, 0,  32'h0,         4'b0000, 1'b1, 1};
    vecs[4]  = '{32'h0000_7F00, 32'hA5A5_5A5A, 4'b1111, 1,  32'hCAFE_0001, 4'b0010, 1'b0, 3};
    vecs[5]  = '{32'h0000_7F20, 32'h0,         4'b0000, -1, 32'h0,         4'b1000, 1'b1, 16};
    vecs[6]  = '{32'h0000_2FFF, 32'h0,         4'b0000, 0,  32'h0F0F_0F0F, 4'b0001, 1'b0, 2};
    vecs[7]  = '{32'h0000_3000, 32'h0,         4'b0000, 0,  32'h0,         4'b0000, 1'b1, 1};
    vecs[8]  = '{32'h0000_7F0B, 32'h7777_0000, 4'b1111, 2,  32'h2468_ACE0, 4'b0010, 1'b0, 4};
    vecs[9]  = '{32'h0000_7F0C, 32'h0,         4'b0000, 0,  32'h0,         4'b0000, 1'b1, 1};
    vecs[10] = '{32'h0000_7F23, 32'h0,         4'b0000, 0,  32'h1357_9BDF, 4'b1000, 1'b0, 2};
    vecs[11] = '{32'h0000_7F24, 32'h0,         4'b0000, 0,  32'h0,         4'b0000, 1'b1, 1};
    vecs[12] = '{32'h0000_7F1B, 32'h0,         4'b0000, 0,  32'h5555_AAAA, 4'b0100, 1'b0, 2};
    vecs[13] = '{32'h0000_7F10, 32'h0,         4'b1100, 0,  32'h0,         4'b0000, 1'b1, 1};
    vecs[14] = '{32'h0000_0000, 32'h0000_00FF, 4'b0001, 4,  32'h0000_0042, 4'b0001, 1'b0, 6};

    bus.pr_req    = 1'b0;
    bus.pr_addr   = '0;
    bus.pr_wdata  = '0;
    bus.pr_byteen = '0;
    bus.slv_ready = '0;
    bus.slv_rdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of an access drops it without a completion pulse.
    bus.pr_req    = 1'b1;
    bus.pr_addr   = 32'h0000_7F20;
    bus.pr_wdata  = 32'h9999_9999;
    bus.pr_byteen = 4'b1111;
    n = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.slv_sel == 4'b1000) n++;
    end
    check("rst_pre sel_cyc", 32'(n), 32'd3);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_async");
    n = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.pr_done) n++;
    end
    check("rst_hold done_cnt", 32'(n), 32'd0);
    check_all_zero("rst_hold");
    bus.pr_req = 1'b0;
    reset = 1'b0;
    rv = '{32'h0000_0000, 32'h0, 4'b0000, 1, 32'h600D_F00D, 4'b0001, 1'b0, 3};
    run_vec(rv, "post_rst");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
